// File: rtl/dm_store_merge.sv
// dm_store_merge: store-side front end of the data memory.
// The memory only writes whole 32-bit words, so sw is forwarded directly
// while sb/sh run a read-modify-write (IDLE -> MERGE -> WRITE).
// Loads pass straight through to the memory while IDLE.
// Optional build macro: DMST_MISALIGN_TRAP_EN
//   defined     : sh with cpu_addr[0]=1 is dropped and st_err pulses for one cycle
//   not defined : sh with cpu_addr[0]=1 is aligned down and st_err is tied 0
//
// Handshake: a store is taken in any cycle where st_req && st_ready. While
// st_ready is low (stall high) the request is not seen; upstream holds
// st_req/st_sel/cpu_addr/cpu_wdata steady until it is taken.
module dm_store_merge #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_req,
  input  logic [1:0]    st_sel,
  input  logic [AW+1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [3:0]    cpu_ldsel,
  output logic          st_ready,
  output logic          stall,
  output logic          st_err,
  output logic [AW-1:0] dm_addr,
  output logic [1:0]    dm_byte,
  output logic [3:0]    dm_ldsel,
  output logic          dm_wr,
  output logic [DW-1:0] dm_din,
  input  logic [DW-1:0] dm_dout,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MERGE = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_lane;
  logic          r_half;
  logic [15:0]   r_wdata;
  logic [DW-1:0] r_merged;

  logic          w_idle;
  logic          w_is_sw;
  logic          w_is_sb;
  logic          w_is_sh;
  logic          w_drop;
  logic          w_take_rmw;
  logic [1:0]    w_lane_in;
  logic [DW-1:0] w_merged;

  assign w_idle  = (r_state == S_IDLE);
  assign w_is_sw = (st_sel == 2'b00);
  assign w_is_sb = (st_sel == 2'b01);
  assign w_is_sh = (st_sel == 2'b10);

`ifdef DMST_MISALIGN_TRAP_EN
  logic w_sh_misaligned;
  assign w_sh_misaligned = w_is_sh & cpu_addr[0];
  // Misaligned halfword stores are refused and reported.
  assign w_drop = w_sh_misaligned;
  assign st_err = w_idle & st_req & w_sh_misaligned & ~rst;
`else
  // Misaligned halfword stores are aligned down via w_lane_in below.
  assign w_drop = 1'b0;
  assign st_err = 1'b0;
`endif

  // Halfword lanes are 0 or 2: address bit 0 is ignored for sh.
  assign w_lane_in  = w_is_sh ? {cpu_addr[1], 1'b0} : cpu_addr[1:0];
  assign w_take_rmw = w_idle & st_req & (w_is_sb | (w_is_sh & ~w_drop));

  // Old word from memory with the latched lane(s) replaced; no sign extension.
  always_comb begin
    w_merged = dm_dout;
    if (r_half) begin
      if (r_lane[1]) w_merged[31:16] = r_wdata[15:0];
      else           w_merged[15:0]  = r_wdata[15:0];
    end else begin
      case (r_lane)
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end
  end

  // RMW sequencer: latch sb/sh in IDLE, capture merged word in MERGE, write in WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_lane   <= 2'b00;
      r_half   <= 1'b0;
      r_wdata  <= 16'h0000;
      r_merged <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take_rmw) begin
            r_addr  <= cpu_addr[AW+1:2];
            r_lane  <= w_lane_in;
            r_half  <= w_is_sh;
            r_wdata <= cpu_wdata[15:0];
            r_state <= S_MERGE;
          end
        end
        S_MERGE: begin
          r_merged <= w_merged;
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory bus: CPU owns it in IDLE, the RMW owns it (as a lw read/write) otherwise.
  always_comb begin
    dm_addr  = r_addr;
    dm_byte  = 2'b00;
    dm_ldsel = 4'b0000;
    dm_wr    = 1'b0;
    dm_din   = r_merged;
    if (w_idle) begin
      dm_addr  = cpu_addr[AW+1:2];
      dm_byte  = cpu_addr[1:0];
      dm_ldsel = cpu_ldsel;
      dm_din   = cpu_wdata;
      dm_wr    = st_req & w_is_sw & ~rst;
    end else if (r_state == S_WRITE) begin
      dm_wr = ~rst;
    end
  end

  // Reset wins over an in-flight RMW, so the stall drops in the reset cycle.
  assign stall     = ~w_idle & ~rst;
  assign st_ready  = ~stall;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dm_store_merge.sv
// Testbench for dm_store_merge: a word memory model answers the DUT bus,
// a byte-addressed reference memory predicts every store outcome.
module tb_dm_store_merge;

  logic        clk;
  logic        rst;
  logic        st_req;
  logic [1:0]  st_sel;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_ldsel;
  logic        st_ready;
  logic        stall;
  logic        st_err;
  logic [6:0]  dm_addr;
  logic [1:0]  dm_byte;
  logic [3:0]  dm_ldsel;
  logic        dm_wr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic [1:0]  dbg_state;

  dm_store_merge #(.AW(7), .DW(32)) dut (
    .clk(clk), .rst(rst), .st_req(st_req), .st_sel(st_sel),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ldsel(cpu_ldsel),
    .st_ready(st_ready), .stall(stall), .st_err(st_err),
    .dm_addr(dm_addr), .dm_byte(dm_byte), .dm_ldsel(dm_ldsel),
    .dm_wr(dm_wr), .dm_din(dm_din), .dm_dout(dm_dout), .dbg_state(dbg_state)
  );

`ifdef DMST_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // ---------------- clock / reset / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [128];
  int          wr_count;
  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_wr) begin
      mem[dm_addr] <= dm_din;
      wr_count     <= wr_count + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_q[$];
  logic [7:0]  ref_bytes [512];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory updated from the store rules.
  task automatic ref_store(input logic [1:0] sel, input logic [8:0] a, input logic [31:0] d);
    int base;
    case (sel)
      2'b00: begin
        base = int'(a) & ~3;
        for (int i = 0; i < 4; i++) ref_bytes[base + i] = d[8*i +: 8];
      end
      2'b01: ref_bytes[int'(a)] = d[7:0];
      2'b10: begin
        if (!(TRAP && a[0])) begin
          base = int'(a) & ~1;
          ref_bytes[base]     = d[7:0];
          ref_bytes[base + 1] = d[15:8];
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
  endfunction

  // ---------------- driver ----------------
  // Issue one store, report dm_wr/st_err seen in the accept cycle and the
  // number of cycles stall stayed high afterwards.
  task automatic do_store(input logic [1:0] sel, input logic [8:0] a, input logic [31:0] d,
                          output int n_stall, output logic wr0, output logic err0);
    int guard;
    @(negedge clk);
    st_req = 1'b1; st_sel = sel; cpu_addr = a; cpu_wdata = d;
    #1;
    guard = 0;
    while (!st_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: st_ready stuck at %b want 1", st_ready);
    end
    wr0  = dm_wr;
    err0 = st_err;
    @(posedge clk); #1;
    st_req = 1'b0;
    n_stall = 0;
    while (stall && n_stall < 20) begin
      n_stall++;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp;
    int          exp_stall;
    logic        exp_wr0;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          ns;
    logic        w0;
    logic        e0;
    int          wc0;
    int          bad_words;
    logic [1:0]  rs;
    logic [8:0]  ra;
    logic [31:0] rd;
    logic [31:0] ew;
    bit          mis;

    n_cmp = 0; n_bad = 0; wr_count = 0;
    rst = 1'b1; st_req = 1'b0; st_sel = 2'b00; cpu_addr = '0; cpu_wdata = '0; cpu_ldsel = '0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;

    vecs[0] = '{"sw_word4",     2'b00, 9'h010, 32'h12345678, 32'h00000000, 32'h12345678, 0, 1'b1, 1'b0};
    vecs[1] = '{"sb_lane2",     2'b01, 9'h012, 32'h000000AB, 32'h12345678, 32'h12AB5678, 2, 1'b0, 1'b0};
    vecs[2] = '{"sh_upper",     2'b10, 9'h016, 32'h00000000, 32'hFFFFFFFF, 32'h0000FFFF, 2, 1'b0, 1'b0};
    vecs[3] = '{"sh_lower",     2'b10, 9'h014, 32'h00001111, 32'h0000FFFF, 32'h00001111, 2, 1'b0, 1'b0};
    vecs[4] = '{"sb_lane3",     2'b01, 9'h043, 32'hFFFFFF77, 32'h01020304, 32'h77020304, 2, 1'b0, 1'b0};
    vecs[5] = '{"sb_lane0",     2'b01, 9'h040, 32'h1234565A, 32'h00000000, 32'h0000005A, 2, 1'b0, 1'b0};
    vecs[6] = '{"sel11_noop",   2'b11, 9'h050, 32'hDEADBEEF, 32'h11111111, 32'h11111111, 0, 1'b0, 1'b0};
    if (TRAP) begin
      vecs[7] = '{"sh_mis_013", 2'b10, 9'h013, 32'h0000BEEF, 32'h12345678, 32'h12345678, 0, 1'b0, 1'b1};
      vecs[8] = '{"sh_mis_061", 2'b10, 9'h061, 32'h00009876, 32'hAAAAAAAA, 32'hAAAAAAAA, 0, 1'b0, 1'b1};
    end else begin
      vecs[7] = '{"sh_mis_013", 2'b10, 9'h013, 32'h0000BEEF, 32'h12345678, 32'hBEEF5678, 2, 1'b0, 1'b0};
      vecs[8] = '{"sh_mis_061", 2'b10, 9'h061, 32'h00009876, 32'hAAAAAAAA, 32'hAAAA9876, 2, 1'b0, 1'b0};
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_ready", {31'b0, st_ready}, 32'h1);
    check("rst_dm_wr", {31'b0, dm_wr}, 32'h0);
    check("rst_st_err", {31'b0, st_err}, 32'h0);
    rst = 1'b0;

    // Table-driven stores
    foreach (vecs[i]) begin
      @(negedge clk);
      mem[vecs[i].addr[8:2]] = vecs[i].init;
      do_store(vecs[i].sel, vecs[i].addr, vecs[i].wdata, ns, w0, e0);
      check({vecs[i].name, "_word"}, mem[vecs[i].addr[8:2]], vecs[i].exp);
      check({vecs[i].name, "_stall"}, ns, vecs[i].exp_stall);
      check({vecs[i].name, "_wr0"}, {31'b0, w0}, {31'b0, vecs[i].exp_wr0});
      check({vecs[i].name, "_err"}, {31'b0, e0}, {31'b0, vecs[i].exp_err});
    end

    // Load pass-through while idle
    @(negedge clk);
    mem[4] = 32'h12AB5678;
    cpu_addr = 9'h013; cpu_ldsel = 4'b0101;
    #1;
    check("ld_addr", {25'b0, dm_addr}, 32'd4);
    check("ld_byte", {30'b0, dm_byte}, 32'd3);
    check("ld_ldsel", {28'b0, dm_ldsel}, 32'h5);
    check("ld_dout", dm_dout, 32'h12AB5678);
    check("ld_no_wr", {31'b0, dm_wr}, 32'h0);

    // Back-to-back sb to the same word; second is held by the stall
    @(negedge clk);
    mem[8] = 32'hA5A5A5A5;
    st_req = 1'b1; st_sel = 2'b01; cpu_addr = 9'h020; cpu_wdata = 32'h00000001;
    #1;
    check("b2b_first_ready", {31'b0, st_ready}, 32'h1);
    @(posedge clk); #1;
    cpu_addr = 9'h021; cpu_wdata = 32'h00000002;
    ns = 0;
    while (!st_ready && ns < 20) begin
      ns++;
      @(posedge clk); #1;
    end
    check("b2b_held_cycles", ns, 32'd2);
    @(posedge clk); #1;
    st_req = 1'b0;
    ns = 0;
    while (stall && ns < 20) begin
      ns++;
      @(posedge clk); #1;
    end
    check("b2b_word8", mem[8], 32'hA5A50201);

    // Reset during MERGE aborts the RMW
    @(negedge clk);
    mem[12] = 32'hCAFEBABE;
    wc0 = wr_count;
    st_req = 1'b1; st_sel = 2'b01; cpu_addr = 9'h030; cpu_wdata = 32'h00000099;
    @(posedge clk); #1;
    st_req = 1'b0;
    rst = 1'b1;
    #1;
    check("rstm_dm_wr", {31'b0, dm_wr}, 32'h0);
    check("rstm_stall", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstm_idle_ready", {31'b0, st_ready}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("rstm_no_write", wr_count, wc0);
    check("rstm_word12", mem[12], 32'hCAFEBABE);

    // Reset during WRITE suppresses the write
    @(negedge clk);
    wc0 = wr_count;
    st_req = 1'b1; st_sel = 2'b10; cpu_addr = 9'h030; cpu_wdata = 32'h00004444;
    @(posedge clk); #1;
    st_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstw_dm_wr", {31'b0, dm_wr}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstw_no_write", wr_count, wc0);
    check("rstw_word12", mem[12], 32'hCAFEBABE);

    // Randomized stores against the byte-level reference
    @(negedge clk);
    for (int w = 0; w < 128; w++) begin
      mem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_bytes[4*w + b] = mem[w][8*b +: 8];
    end
    for (int n = 0; n < 150; n++) begin
      rs = 2'($urandom_range(0, 3));
      ra = 9'($urandom_range(0, 511));
      rd = $urandom;
      mis = (rs == 2'b10) && ra[0];
      ref_store(rs, ra, rd);
      exp_q.push_back(ref_word(int'(ra[8:2])));
      do_store(rs, ra, rd, ns, w0, e0);
      ew = exp_q.pop_front();
      check("rnd_word", mem[ra[8:2]], ew);
      check("rnd_stall", ns, ((rs == 2'b01) || (rs == 2'b10 && !(TRAP && mis))) ? 32'd2 : 32'd0);
      check("rnd_wr0", {31'b0, w0}, {31'b0, rs == 2'b00});
      check("rnd_err", {31'b0, e0}, {31'b0, TRAP && mis});
    end
    bad_words = 0;
    for (int w = 0; w < 128; w++) if (mem[w] !== ref_word(w)) bad_words++;
    check("rnd_final_mem_bad_words", bad_words, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so a stuck DUT cannot hang the run
  initial begin
    #500000;
    $display("FAIL watchdog: run time exceeded limit, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
